// File: rtl/selen_boot_pkg.sv
// Shared types and constants for the boot controller.
package selen_boot_pkg;

    // Boot sequencer states
    typedef enum logic [2:0] {
        ST_RESET      = 3'd0,
        ST_CACHE_RST  = 3'd1,
        ST_CACHE_INIT = 3'd2,
        ST_CORE_DELAY = 3'd3,
        ST_RUN        = 3'd4,
        ST_ERROR      = 3'd5
    } boot_state_t;

    // Width of the shared phase counter
    localparam int CNT_W = 16;

    // Parameter defaults
    localparam int DEF_RST_SYNC_STAGES   = 2;
    localparam int DEF_CACHE_RST_CYCLES  = 5;
    localparam int DEF_CORE_DELAY_CYCLES = 4;
    localparam int DEF_TIMEOUT_CYCLES    = 1024;

endpackage

// File: rtl/selen_boot_ctrl_rst_sync.sv
// Reset synchronizer: asserts asynchronously, releases STAGES clocks after rst falls.
module selen_rst_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    output logic rst_sync
);

    logic [STAGES-1:0] sync_reg;

    // Shift zeros in once rst is gone; rst sets every stage immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], 1'b0};
        end
    end

    assign rst_sync = sync_reg[STAGES-1];

endmodule

// File: rtl/selen_boot_ctrl.sv
// Boot sequencer: cache reset, wait for cache init (with timeout), core release delay.
module selen_boot_ctrl
    import selen_boot_pkg::*;
#(
    parameter int RST_SYNC_STAGES   = DEF_RST_SYNC_STAGES,
    parameter int CACHE_RST_CYCLES  = DEF_CACHE_RST_CYCLES,
    parameter int CORE_DELAY_CYCLES = DEF_CORE_DELAY_CYCLES,
    parameter int TIMEOUT_CYCLES    = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic cache_ready,
    output logic cache_rst_n,
    output logic core_rst_n,
    output logic boot_done,
    output logic boot_timeout
);

    // Terminal counts: each phase ends when the counter reaches N-1
    localparam logic [CNT_W-1:0] CACHE_RST_LAST  = CNT_W'(CACHE_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CORE_DELAY_LAST = CNT_W'(CORE_DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

    logic              rst_int;
    boot_state_t       state_reg;
    logic [CNT_W-1:0]  cnt_reg;

    selen_rst_sync #(
        .STAGES (RST_SYNC_STAGES)
    ) u_rst_sync (
        .clk      (clk),
        .rst      (rst),
        .rst_sync (rst_int)
    );

    // Sequencer: outputs are loaded together with the state they belong to,
    // so every output changes on the edge that enters its state
    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            state_reg    <= ST_RESET;
            cnt_reg      <= '0;
            cache_rst_n  <= 1'b0;
            core_rst_n   <= 1'b0;
            boot_done    <= 1'b0;
            boot_timeout <= 1'b0;
        end else begin
            case (state_reg)
                ST_RESET: begin
                    state_reg   <= ST_CACHE_RST;
                    cnt_reg     <= '0;
                    cache_rst_n <= 1'b0;
                    core_rst_n  <= 1'b0;
                end
                ST_CACHE_RST: begin
                    if (cnt_reg == CACHE_RST_LAST) begin
                        state_reg   <= ST_CACHE_INIT;
                        cnt_reg     <= '0;
                        cache_rst_n <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_CACHE_INIT: begin
                    // cache_ready is checked first so it beats a coincident timeout
                    if (cache_ready) begin
                        state_reg <= ST_CORE_DELAY;
                        cnt_reg   <= '0;
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        state_reg    <= ST_ERROR;
                        cnt_reg      <= '0;
                        cache_rst_n  <= 1'b0;
                        boot_timeout <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_CORE_DELAY: begin
                    if (cnt_reg == CORE_DELAY_LAST) begin
                        state_reg  <= ST_RUN;
                        cnt_reg    <= '0;
                        core_rst_n <= 1'b1;
                        boot_done  <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_RUN, ST_ERROR: begin
                    // Terminal until reset; counter frozen so it cannot wrap
                    state_reg <= state_reg;
                end
                default: begin
                    state_reg    <= ST_RESET;
                    cnt_reg      <= '0;
                    cache_rst_n  <= 1'b0;
                    core_rst_n   <= 1'b0;
                    boot_done    <= 1'b0;
                    boot_timeout <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_selen_boot_ctrl.sv
// Directed bench for selen_boot_ctrl: default instance plus a 16-cycle-timeout instance.
module tb_selen_boot_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ready_a = 1'b0;
    logic ready_b = 1'b0;
    logic cache_a, core_a, done_a, to_a;
    logic cache_b, core_b, done_b, to_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    selen_boot_ctrl dut_a (
        .clk          (clk),
        .rst          (rst),
        .cache_ready  (ready_a),
        .cache_rst_n  (cache_a),
        .core_rst_n   (core_a),
        .boot_done    (done_a),
        .boot_timeout (to_a)
    );

    selen_boot_ctrl #(
        .TIMEOUT_CYCLES (16)
    ) dut_b (
        .clk          (clk),
        .rst          (rst),
        .cache_ready  (ready_b),
        .cache_rst_n  (cache_b),
        .core_rst_n   (core_b),
        .boot_done    (done_b),
        .boot_timeout (to_b)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic cr, input logic co,
                         input logic bd, input logic bt);
        chk({tag, " a.cache_rst_n"}, cache_a, cr);
        chk({tag, " a.core_rst_n"},  core_a,  co);
        chk({tag, " a.boot_done"},   done_a,  bd);
        chk({tag, " a.boot_timeout"}, to_a,   bt);
    endtask

    task automatic chk_b(input string tag, input logic cr, input logic co,
                         input logic bd, input logic bt);
        chk({tag, " b.cache_rst_n"}, cache_b, cr);
        chk({tag, " b.core_rst_n"},  core_b,  co);
        chk({tag, " b.boot_done"},   done_b,  bd);
        chk({tag, " b.boot_timeout"}, to_b,   bt);
    endtask

    // Advance n rising edges, then settle 1 ns past the edge
    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold rst for 3 clocks, check reset values, release just after an edge
    task automatic do_reset(input string tag);
        rst = 1'b1;
        adv(3);
        chk_a(tag, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_b(tag, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Full sequence, cache_ready tied high
        ready_a = 1'b1;
        ready_b = 1'b1;
        do_reset("reset1");
        adv(7);
        chk_a("e7", 1'b0, 1'b0, 1'b0, 1'b0);
        adv(1);
        chk_a("e8", 1'b1, 1'b0, 1'b0, 1'b0);
        chk_b("e8", 1'b1, 1'b0, 1'b0, 1'b0);
        adv(4);
        chk_a("e12", 1'b1, 1'b0, 1'b0, 1'b0);
        adv(1);
        chk_a("e13", 1'b1, 1'b1, 1'b1, 1'b0);
        chk_b("e13", 1'b1, 1'b1, 1'b1, 1'b0);
        $display("[TB] txn boot_ready_high done");

        // cache_ready noise while in RUN
        for (int i = 0; i < 6; i++) begin
            ready_a = 1'($urandom_range(0, 1));
            adv(1);
            chk_a("run_noise", 1'b1, 1'b1, 1'b1, 1'b0);
        end
        $display("[TB] txn run_noise done");

        // Async rst pulse during CORE_DELAY
        ready_a = 1'b1;
        do_reset("reset2");
        adv(10);
        #3 rst = 1'b1;
        #1 chk_a("pulse_core_delay", 1'b0, 1'b0, 1'b0, 1'b0);
        #1 rst = 1'b0;
        // Replay with cache_ready noise during RESET/CACHE_RST
        for (int i = 1; i <= 7; i++) begin
            ready_a = 1'($urandom_range(0, 1));
            adv(1);
            chk("cache_rst_noise cache", cache_a, 1'b0);
            chk("cache_rst_noise core",  core_a,  1'b0);
        end
        ready_a = 1'b1;
        adv(1);
        chk_a("replay1 e8", 1'b1, 1'b0, 1'b0, 1'b0);
        adv(4);
        chk_a("replay1 e12", 1'b1, 1'b0, 1'b0, 1'b0);
        adv(1);
        chk_a("replay1 e13", 1'b1, 1'b1, 1'b1, 1'b0);
        $display("[TB] txn pulse_in_core_delay done");

        // Async rst pulse in RUN
        adv(2);
        #3 rst = 1'b1;
        #1 chk_a("pulse_run", 1'b0, 1'b0, 1'b0, 1'b0);
        #1 rst = 1'b0;
        adv(7);
        chk_a("replay2 e7", 1'b0, 1'b0, 1'b0, 1'b0);
        adv(1);
        chk_a("replay2 e8", 1'b1, 1'b0, 1'b0, 1'b0);
        adv(4);
        chk_a("replay2 e12", 1'b1, 1'b0, 1'b0, 1'b0);
        adv(1);
        chk_a("replay2 e13", 1'b1, 1'b1, 1'b1, 1'b0);
        $display("[TB] txn pulse_in_run done");

        // a: one-clock ready pulse at 10th CACHE_INIT clock; b: timeout
        ready_a = 1'b0;
        ready_b = 1'b0;
        do_reset("reset3");
        adv(8);
        chk_a("init e8", 1'b1, 1'b0, 1'b0, 1'b0);
        chk_b("init e8", 1'b1, 1'b0, 1'b0, 1'b0);
        adv(9);
        ready_a = 1'b1;
        adv(1);
        ready_a = 1'b0;
        chk_a("pulse e18", 1'b1, 1'b0, 1'b0, 1'b0);
        adv(3);
        chk_a("pulse e21", 1'b1, 1'b0, 1'b0, 1'b0);
        adv(1);
        chk_a("pulse e22", 1'b1, 1'b1, 1'b1, 1'b0);
        $display("[TB] txn ready_pulse done");
        adv(1);
        chk_b("timeout e23", 1'b1, 1'b0, 1'b0, 1'b0);
        adv(1);
        chk_b("timeout e24", 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            ready_b = 1'($urandom_range(0, 1));
            adv(1);
            chk_b("error_hold", 1'b0, 1'b0, 1'b0, 1'b1);
        end
        $display("[TB] txn timeout done");

        // b: cache_ready arrives on the same edge the timeout would fire
        ready_a = 1'b1;
        ready_b = 1'b0;
        do_reset("reset4");
        adv(23);
        chk_b("race e23", 1'b1, 1'b0, 1'b0, 1'b0);
        ready_b = 1'b1;
        adv(1);
        chk_b("race e24", 1'b1, 1'b0, 1'b0, 1'b0);
        adv(3);
        chk_b("race e27", 1'b1, 1'b0, 1'b0, 1'b0);
        adv(1);
        chk_b("race e28", 1'b1, 1'b1, 1'b1, 1'b0);
        chk_a("race e28", 1'b1, 1'b1, 1'b1, 1'b0);
        $display("[TB] txn ready_beats_timeout done");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/selen_boot_ctrl.md
SELEN_BOOT_CTRL -- requirements
Module: selen_boot_ctrl

Interface
REQ-001 Parameter RST_SYNC_STAGES, default 2: number of reset-synchronizer flops (legal 2..4).
REQ-002 Parameter CACHE_RST_CYCLES, default 5: clocks the cache is held in reset after the synchronized reset releases (legal 1..65535).
REQ-003 Parameter CORE_DELAY_CYCLES, default 4: clocks between cache_ready and core reset release (legal 1..65535).
REQ-004 Parameter TIMEOUT_CYCLES, default 1024: maximum clocks spent waiting for cache_ready (legal 1..65535).
REQ-005 clk  input  1  the single system clock; all state updates occur on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 cache_ready  input  1  L1 cache initialization complete; synchronous to clk.
REQ-008 cache_rst_n  output  1  active-low reset to the L1 cache; registered.
REQ-009 core_rst_n  output  1  active-low reset to the CPU core; registered.
REQ-010 boot_done  output  1  high while the FSM is in RUN.
REQ-011 boot_timeout  output  1  high while the FSM is in ERROR.

Function
REQ-012 rst asserts the internal reset asynchronously.
REQ-013 The internal reset deasserts synchronously, RST_SYNC_STAGES rising edges after rst falls.
REQ-014 FSM states: RESET, CACHE_RST, CACHE_INIT, CORE_DELAY, RUN, ERROR.
REQ-015 FSM state is held at RESET while the internal reset is asserted.
REQ-016 RESET -> CACHE_RST on the first clock after internal reset release; the counter is cleared.
REQ-017 CACHE_RST: cache_rst_n=0, core_rst_n=0; the counter increments each clock.
REQ-018 CACHE_RST -> CACHE_INIT when the counter reaches CACHE_RST_CYCLES-1; the counter is cleared.
REQ-019 CACHE_INIT: cache_rst_n=1, core_rst_n=0.
REQ-020 CACHE_INIT -> CORE_DELAY at the first edge sampling cache_ready=1; the counter is cleared.
REQ-021 cache_ready is ignored in every state other than CACHE_INIT.
REQ-022 CACHE_INIT -> ERROR when the counter reaches TIMEOUT_CYCLES-1 with cache_ready=0.
REQ-023 If cache_ready=1 on the same edge the timeout would fire, the transition to CORE_DELAY wins.
REQ-024 CORE_DELAY: cache_rst_n=1, core_rst_n=0; -> RUN when the counter reaches CORE_DELAY_CYCLES-1.
REQ-025 RUN: cache_rst_n=1, core_rst_n=1, boot_done=1; RUN is terminal until reset, and a drop of cache_ready has no effect.
REQ-026 ERROR: cache_rst_n=0, core_rst_n=0, boot_timeout=1; ERROR is terminal until reset.
REQ-027 The outputs are registered from next-state, so each output changes on the same edge that enters the state that drives it.
REQ-028 The counter is 16 bits wide, unsigned, and never wraps: it is cleared on every state transition.

Reset
REQ-029 While the internal reset is asserted: cache_rst_n=0, core_rst_n=0, boot_done=0, boot_timeout=0, counter=0, state=RESET.
REQ-030 rst asserted in any state, including mid-sequence, RUN and ERROR, immediately forces the REQ-029 values and restarts the full sequence.

Structure
REQ-031 Package selen_boot_pkg holds the FSM state enum, the counter width constant (16) and the parameter defaults.
REQ-032 The reset synchronizer is sub-module selen_rst_sync, with parameter STAGES and ports clk, rst, rst_sync; it is instantiated once.

Verification
REQ-033 Defaults, rst high 3 clocks then low, cache_ready tied 1 -> cache_rst_n rises 2+5+1 edges after rst falls, core_rst_n rises 5 edges later, boot_done=1 with it.
REQ-034 cache_ready pulsed 1 for one clock at the 10th CACHE_INIT clock -> CORE_DELAY entered on that edge; core_rst_n=1 exactly 4 clocks later.
REQ-035 TIMEOUT_CYCLES=16, cache_ready held 0 -> ERROR after 16 CACHE_INIT clocks, boot_timeout=1, cache_rst_n=0, core_rst_n stays 0.
REQ-036 TIMEOUT_CYCLES=16, cache_ready rises on the 16th CACHE_INIT clock -> CORE_DELAY entered, boot_timeout stays 0.
REQ-037 rst pulsed asynchronously (mid-cycle, 2 ns) during CORE_DELAY and again in RUN -> all outputs return to reset values without waiting for a clock edge, and the full sequence replays with identical timing.
REQ-038 cache_ready toggled randomly in RUN and in CACHE_RST -> no output change.
